nes_joypad: RTL and testbench
=============================

# nes_joypad

Converts the PS/2 keyboard scancode stream into two NES controller states and serves them to the CPU through the standard $4016/$4017 strobe-and-shift serial protocol. It sits between the PS/2 receiver (upstream, one strobe per received byte) and the CPU/PPU register decode (downstream). It replaces ad-hoc scancode decoding at top level with a prefix-aware parser and a cycle-exact controller shift register.

## Interface
- BLOCK_OPPOSITE, default 1: when 1, Up+Down pressed together reports neither, and Left+Right pressed together reports neither.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_data  in  8  received PS/2 byte (scancode set 2).
- ps2_valid  in  1  one-cycle strobe; ps2_data is valid this cycle.
- strobe_wr  in  1  one-cycle pulse: CPU write to $4016.
- strobe_din  in  1  bit 0 of the CPU write data.
- rd1  in  1  one-cycle pulse: CPU read of $4016 completes.
- rd2  in  1  one-cycle pulse: CPU read of $4017 completes.
- dout1  out  8  $4016 read data: {7'b0100000, sh1[0]}.
- dout2  out  8  $4017 read data: {7'b0100000, sh2[0]}.
- joy1  out  8  live pad 1 state, post-masking.
- joy2  out  8  live pad 2 state, post-masking.

## Operation
- Bit order, both pads: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right. 1 means pressed.
- Pad 1 key map:
  - Z (1A) = A, X (22) = B, C (21) = Select, V (2A) = Start.
  - Arrows, all E0-prefixed: E0 75 = Up, E0 72 = Down, E0 6B = Left, E0 74 = Right.
- Pad 2 key map: K (42) = A, J (3B) = B, Q (15) = Select, E (24) = Start, W (1D) = Up, S (1B) = Down, A (1C) = Left, D (23) = Right.
- Parser FSM, advancing only on ps2_valid:
  - IDLE: F0 → BRK; E0 → EXT; E1 → SKIP with cnt=7; any other byte is a make code → IDLE.
  - BRK: the byte is a break code → IDLE.
  - EXT: F0 → EXTBRK; any other byte is an extended make → IDLE.
  - EXTBRK: the byte is an extended break → IDLE.
  - SKIP: decrement cnt on each byte; leave for IDLE when cnt reaches 0 (this swallows the Pause sequence).
- Make sets the mapped bit; break clears it. Unmapped codes change only FSM state.
- An extended code matches only extended map entries, and a non-extended code matches only non-extended entries. Example: E0 1A does not press A.
- Masking is combinational on the raw state, per BLOCK_OPPOSITE, to produce joy1/joy2.
- Strobe register `stb` is loaded from strobe_din on strobe_wr.
- Shift registers sh1/sh2 (8 bit):
  - While stb=1, each cycle sh1<=joy1 and sh2<=joy2.
  - While stb=0, rd1 shifts sh1 right with 1 shifted in at bit 7; rd2 does the same for sh2. Each port shifts only on its own rd pulse.
  - After 8 reads the port returns 1 indefinitely.
- While stb=1, a read returns the current A bit and does not shift.

## Timing
- Reset values: FSM=IDLE, cnt=0, raw pad state=0, stb=0, sh1=sh2=8'hFF. Resulting outputs: joy1=joy2=0, dout1=dout2=8'h41.
- Reset overrides all other inputs in the same cycle. A reset in the middle of a prefix sequence discards the prefix.
- Key latency: joy outputs change the cycle after the ps2_valid carrying the final byte of a make or break.
- dout is combinational from sh[0]. The CPU samples it during the rd pulse cycle, and the shift takes effect on the following edge.
- strobe_wr with strobe_din=0 takes effect on the next edge. The last load (stb=1 cycle) captures joy at that edge. rd in the same cycle as strobe_wr sees the old stb.
- ps2_valid and a CPU access in the same cycle are independent and both take effect.
- Back-to-back ps2_valid on consecutive cycles must be accepted; there are no stall outputs.

## Test plan
- Reset, then read $4016 nine times with stb=0 → dout1=8'h41 every time.
- Bytes 1A, then E0 74 → joy1=8'h81; then F0 1A → joy1=8'h80; then E0 F0 74 → joy1=8'h00.
- Pad 1 holding A+Start+Right (8'h89), write 1 then 0 to $4016, then 10 reads → dout1[0]=1,0,0,1,0,0,0,1,1,1.
- BLOCK_OPPOSITE=1: W then S make codes → joy2=8'h00; S break → joy2=8'h10. With BLOCK_OPPOSITE=0, W+S → joy2=8'h30.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 22 → only joy1=8'h02; FSM returns to IDLE.
- E0 followed by reset, then 75 → no extended decode; joy1 unchanged at 8'h00.

Source files
------------

// File: rtl/nes_joypad.sv
// PS/2 set-2 scancode parser feeding two NES pads, served through $4016/$4017.
// Ports: clk, reset, ps2_data/ps2_valid in; strobe_wr/strobe_din/rd1/rd2 CPU; dout1/2, joy1/2 out.
module nes_joypad #(
  parameter bit BLOCK_OPPOSITE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  input  logic       strobe_wr,
  input  logic       strobe_din,
  input  logic       rd1,
  input  logic       rd2,
  output logic [7:0] dout1,
  output logic [7:0] dout2,
  output logic [7:0] joy1,
  output logic [7:0] joy2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXTBRK,
    S_SKIP
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] pad1_q, pad1_d;
  logic [7:0] pad2_q, pad2_d;
  logic       stb_q, stb_d;
  logic [7:0] sh1_q, sh1_d;
  logic [7:0] sh2_q, sh2_d;

  logic       key_ev;
  logic       key_make;
  logic       key_ext;
  logic [7:0] m1, m2;

  // Parser: key_ev marks the byte that completes a make or break.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_ev   = 1'b0;
    key_make = 1'b0;
    key_ext  = 1'b0;
    if (ps2_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (ps2_data == 8'hF0) begin
            state_d = S_BRK;
          end else if (ps2_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (ps2_data == 8'hE1) begin
            state_d = S_SKIP;
            cnt_d   = 3'd7;
          end else begin
            key_ev   = 1'b1;
            key_make = 1'b1;
          end
        end
        S_BRK: begin
          key_ev  = 1'b1;
          state_d = S_IDLE;
        end
        S_EXT: begin
          if (ps2_data == 8'hF0) begin
            state_d = S_EXTBRK;
          end else begin
            key_ev   = 1'b1;
            key_make = 1'b1;
            key_ext  = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_EXTBRK: begin
          key_ev  = 1'b1;
          key_ext = 1'b1;
          state_d = S_IDLE;
        end
        S_SKIP: begin
          cnt_d = cnt_q - 3'd1;
          // Last byte of the Pause sequence returns to IDLE.
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Key map: extended and plain codes live in separate tables.
  always_comb begin
    m1 = 8'h00;
    m2 = 8'h00;
    if (key_ext) begin
      case (ps2_data)
        8'h75:   m1 = 8'h10;
        8'h72:   m1 = 8'h20;
        8'h6B:   m1 = 8'h40;
        8'h74:   m1 = 8'h80;
        default: m1 = 8'h00;
      endcase
    end else begin
      case (ps2_data)
        8'h1A:   m1 = 8'h01;
        8'h22:   m1 = 8'h02;
        8'h21:   m1 = 8'h04;
        8'h2A:   m1 = 8'h08;
        8'h42:   m2 = 8'h01;
        8'h3B:   m2 = 8'h02;
        8'h15:   m2 = 8'h04;
        8'h24:   m2 = 8'h08;
        8'h1D:   m2 = 8'h10;
        8'h1B:   m2 = 8'h20;
        8'h1C:   m2 = 8'h40;
        8'h23:   m2 = 8'h80;
        default: m2 = 8'h00;
      endcase
    end
  end

  always_comb begin
    pad1_d = pad1_q;
    pad2_d = pad2_q;
    if (key_ev) begin
      if (key_make) begin
        pad1_d = pad1_q | m1;
        pad2_d = pad2_q | m2;
      end else begin
        pad1_d = pad1_q & ~m1;
        pad2_d = pad2_q & ~m2;
      end
    end
  end

  function automatic logic [7:0] mask_opp(input logic [7:0] p);
    logic [7:0] r;
    r = p;
    if (BLOCK_OPPOSITE) begin
      if (p[4] && p[5]) r[5:4] = 2'b00;
      if (p[6] && p[7]) r[7:6] = 2'b00;
    end
    return r;
  endfunction

  assign joy1 = mask_opp(pad1_q);
  assign joy2 = mask_opp(pad2_q);

  // Serial ports: parallel load while strobed, else shift in 1s on reads.
  always_comb begin
    stb_d = strobe_wr ? strobe_din : stb_q;
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    if (stb_q) begin
      sh1_d = joy1;
      sh2_d = joy2;
    end else begin
      if (rd1) sh1_d = {1'b1, sh1_q[7:1]};
      if (rd2) sh2_d = {1'b1, sh2_q[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      pad1_q  <= 8'h00;
      pad2_q  <= 8'h00;
      stb_q   <= 1'b0;
      sh1_q   <= 8'hFF;
      sh2_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pad1_q  <= pad1_d;
      pad2_q  <= pad2_d;
      stb_q   <= stb_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
    end
  end

  assign dout1 = {7'b0100000, sh1_q[0]};
  assign dout2 = {7'b0100000, sh2_q[0]};

endmodule

// File: tb/tb_nes_joypad.sv
// Directed bench for nes_joypad: parser, masking and serial ports.
// Two instances: opposite-blocking on (dut) and off (dut_nb).
module tb_nes_joypad;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_valid = 1'b0;
  logic       strobe_wr = 1'b0;
  logic       strobe_din = 1'b0;
  logic       rd1 = 1'b0;
  logic       rd2 = 1'b0;
  logic [7:0] dout1, dout2, joy1, joy2;
  logic [7:0] dout1_nb, dout2_nb, joy1_nb, joy2_nb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nes_joypad #(.BLOCK_OPPOSITE(1'b1)) dut (
    .clk(clk), .reset(reset), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .strobe_wr(strobe_wr), .strobe_din(strobe_din), .rd1(rd1), .rd2(rd2),
    .dout1(dout1), .dout2(dout2), .joy1(joy1), .joy2(joy2)
  );

  nes_joypad #(.BLOCK_OPPOSITE(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .strobe_wr(strobe_wr), .strobe_din(strobe_din), .rd1(rd1), .rd2(rd2),
    .dout1(dout1_nb), .dout2(dout2_nb), .joy1(joy1_nb), .joy2(joy2_nb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_data  = b;
    ps2_valid = 1'b1;
    tick();
    ps2_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (joy1 !== 8'h00) begin
      failures++;
      $display("FAIL reset_joy1 got=%h exp=00", joy1);
    end
    checks++;
    if (joy2 !== 8'h00) begin
      failures++;
      $display("FAIL reset_joy2 got=%h exp=00", joy2);
    end
    checks++;
    if (dout1 !== 8'h41) begin
      failures++;
      $display("FAIL reset_dout1 got=%h exp=41", dout1);
    end
    checks++;
    if (dout2 !== 8'h41) begin
      failures++;
      $display("FAIL reset_dout2 got=%h exp=41", dout2);
    end
  endtask

  task automatic test_reset_reads();
    for (int i = 0; i < 9; i++) begin
      rd1 = 1'b1;
      #1;
      checks++;
      if (dout1 !== 8'h41) begin
        failures++;
        $display("FAIL reset_read%0d got=%h exp=41", i, dout1);
      end
      tick();
      rd1 = 1'b0;
    end
  endtask

  task automatic test_keys();
    send(8'h1A);
    checks++;
    if (joy1 !== 8'h01) begin
      failures++;
      $display("FAIL make_A got=%h exp=01", joy1);
    end
    send(8'hE0);
    checks++;
    if (joy1 !== 8'h01) begin
      failures++;
      $display("FAIL prefix_only got=%h exp=01", joy1);
    end
    send(8'h74);
    checks++;
    if (joy1 !== 8'h81) begin
      failures++;
      $display("FAIL make_right got=%h exp=81", joy1);
    end
    send(8'hF0);
    send(8'h1A);
    checks++;
    if (joy1 !== 8'h80) begin
      failures++;
      $display("FAIL break_A got=%h exp=80", joy1);
    end
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    checks++;
    if (joy1 !== 8'h00) begin
      failures++;
      $display("FAIL break_right got=%h exp=00", joy1);
    end
    send(8'hE0);
    send(8'h1A);
    checks++;
    if (joy1 !== 8'h00) begin
      failures++;
      $display("FAIL ext_1A got=%h exp=00", joy1);
    end
    send(8'h75);
    checks++;
    if (joy1 !== 8'h00) begin
      failures++;
      $display("FAIL plain_75 got=%h exp=00", joy1);
    end
  endtask

  task automatic test_shift();
    bit e[10];
    e = '{1, 0, 0, 1, 0, 0, 0, 1, 1, 1};
    send(8'h1A);
    send(8'h2A);
    send(8'hE0);
    send(8'h74);
    checks++;
    if (joy1 !== 8'h89) begin
      failures++;
      $display("FAIL hold_89 got=%h exp=89", joy1);
    end
    strobe_wr  = 1'b1;
    strobe_din = 1'b1;
    tick();
    strobe_wr = 1'b0;
    tick();
    rd1 = 1'b1;
    #1;
    checks++;
    if (dout1 !== 8'h41) begin
      failures++;
      $display("FAIL strobed_read got=%h exp=41", dout1);
    end
    tick();
    rd1 = 1'b0;
    strobe_wr  = 1'b1;
    strobe_din = 1'b0;
    tick();
    strobe_wr = 1'b0;
    checks++;
    if (dout2 !== 8'h40) begin
      failures++;
      $display("FAIL pad2_latched got=%h exp=40", dout2);
    end
    for (int i = 0; i < 10; i++) begin
      rd1 = 1'b1;
      #1;
      checks++;
      if (dout1[0] !== e[i]) begin
        failures++;
        $display("FAIL shift_read%0d got=%b exp=%b", i, dout1[0], e[i]);
      end
      tick();
      rd1 = 1'b0;
    end
    checks++;
    if (dout2 !== 8'h40) begin
      failures++;
      $display("FAIL pad2_no_shift got=%h exp=40", dout2);
    end
    send(8'hF0);
    send(8'h1A);
    send(8'hF0);
    send(8'h2A);
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    checks++;
    if (joy1 !== 8'h00) begin
      failures++;
      $display("FAIL release_all got=%h exp=00", joy1);
    end
  endtask

  task automatic test_opposite();
    send(8'h1D);
    checks++;
    if (joy2 !== 8'h10) begin
      failures++;
      $display("FAIL up_only got=%h exp=10", joy2);
    end
    send(8'h1B);
    checks++;
    if (joy2 !== 8'h00) begin
      failures++;
      $display("FAIL up_down_block got=%h exp=00", joy2);
    end
    checks++;
    if (joy2_nb !== 8'h30) begin
      failures++;
      $display("FAIL up_down_noblock got=%h exp=30", joy2_nb);
    end
    send(8'h1C);
    send(8'h23);
    checks++;
    if (joy2 !== 8'h00) begin
      failures++;
      $display("FAIL all_dirs_block got=%h exp=00", joy2);
    end
    checks++;
    if (joy2_nb !== 8'hF0) begin
      failures++;
      $display("FAIL all_dirs_noblock got=%h exp=F0", joy2_nb);
    end
    send(8'hF0);
    send(8'h1B);
    send(8'hF0);
    send(8'h23);
    checks++;
    if (joy2 !== 8'h50) begin
      failures++;
      $display("FAIL up_left got=%h exp=50", joy2);
    end
    send(8'hF0);
    send(8'h1D);
    send(8'hF0);
    send(8'h1C);
    checks++;
    if (joy2 !== 8'h00) begin
      failures++;
      $display("FAIL pad2_clear got=%h exp=00", joy2);
    end
  endtask

  task automatic test_pause();
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    send(8'h77);
    send(8'h22);
    checks++;
    if (joy1 !== 8'h02) begin
      failures++;
      $display("FAIL pause_then_B got=%h exp=02", joy1);
    end
    checks++;
    if (joy2 !== 8'h00) begin
      failures++;
      $display("FAIL pause_joy2 got=%h exp=00", joy2);
    end
    send(8'hF0);
    send(8'h22);
    checks++;
    if (joy1 !== 8'h00) begin
      failures++;
      $display("FAIL pause_release got=%h exp=00", joy1);
    end
  endtask

  task automatic test_reset_prefix();
    send(8'hE0);
    do_reset();
    send(8'h75);
    checks++;
    if (joy1 !== 8'h00) begin
      failures++;
      $display("FAIL reset_drops_prefix got=%h exp=00", joy1);
    end
    send(8'hE0);
    send(8'h75);
    checks++;
    if (joy1 !== 8'h10) begin
      failures++;
      $display("FAIL ext_up got=%h exp=10", joy1);
    end
  endtask

  initial begin
    test_reset();
    test_reset_reads();
    test_keys();
    test_shift();
    test_opposite();
    test_pause();
    test_reset_prefix();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
